l1cache_mem_bridge: RTL and testbench

Sits directly downstream of the L1 cache. Converts its single-cycle cacheline read/write requests (fill and writeback) into word-wide burst transactions on the external memory bus. Reads are assembled into a full cacheline buffer; writes are serialised into beats. Returns one response pulse to the cache per completed line transfer.

---
 rtl/rvga_types.sv | 10 +
 rtl/l1cache_mem_beat_buffer.sv | 44 ++++
 rtl/l1cache_mem_bridge.sv | 107 ++++++++++
 tb/tb_l1cache_mem_bridge.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rvga_types.sv
// rvga_types: shared widths, line/word types and bridge FSM states
package rvga_types;
   localparam int unsigned RVGA_LINE_BITS        = 256;
   localparam int unsigned RVGA_WORD_BITS        = 32;
   localparam int unsigned RVGA_BEATS            = RVGA_LINE_BITS / RVGA_WORD_BITS;
   localparam int unsigned RVGA_LINE_OFFSET_BITS = $clog2(RVGA_LINE_BITS / 8);
   typedef logic [RVGA_LINE_BITS-1:0] rvga_cacheline;
   typedef logic [RVGA_WORD_BITS-1:0] rvga_word;
   typedef enum logic [2:0] {IDLE, CMD_R, CMD_W, RDATA, WDATA, RESP} rvga_bridge_state_e;
endpackage

// File: rtl/l1cache_mem_beat_buffer.sv
// l1cache_mem_beat_buffer: line register plus beat counter, word select for writes and word insert for reads
module l1cache_mem_beat_buffer
   import rvga_types::*;
#(
   parameter int unsigned line_bits = RVGA_LINE_BITS,
   parameter int unsigned word_bits = RVGA_WORD_BITS,
   localparam int unsigned beats    = line_bits / word_bits,
   localparam int unsigned cnt_bits = $clog2(beats)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 adv_i,
   input  logic                 load_i,
   input  logic [word_bits-1:0] word_i,
   input  logic [line_bits-1:0] wline_i,
   output logic [cnt_bits-1:0]  cnt_o,
   output logic [word_bits-1:0] word_o,
   output logic [line_bits-1:0] line_o
);
   logic [cnt_bits-1:0]  cnt_q, cnt_d;
   logic [line_bits-1:0] line_q, line_d;
   logic [31:0]          base;
   assign base   = 32'(cnt_q) * word_bits;
   assign word_o = wline_i[base +: word_bits];
   assign cnt_o  = cnt_q;
   assign line_o = line_q;
   // counter restarts per burst and wraps naturally; loaded beats land at the current word slot
   always_comb begin
      cnt_d  = clr_i ? '0 : (adv_i ? cnt_q + cnt_bits'(1) : cnt_q);
      line_d = line_q;
      if (load_i) line_d[base +: word_bits] = word_i;
   end
   // counter and line register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end
endmodule

// File: rtl/l1cache_mem_bridge.sv
// l1cache_mem_bridge: turns L1 line fill/writeback requests into word-wide memory bursts
module l1cache_mem_bridge
   import rvga_types::*;
#(
   parameter int unsigned line_bits = RVGA_LINE_BITS,
   parameter int unsigned word_bits = RVGA_WORD_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          l1cache_ddr_addr,
   input  logic                 l1cache_ddr_read,
   input  logic                 l1cache_ddr_write,
   input  logic [line_bits-1:0] l1cache_ddr_wdata,
   output logic [line_bits-1:0] ddr_l1cache_rdata,
   output logic                 ddr_l1cache_resp,
   output logic                 mem_cmd_valid,
   input  logic                 mem_cmd_ready,
   output logic                 mem_cmd_write,
   output logic [31:0]          mem_cmd_addr,
   output logic [word_bits-1:0] mem_wdata,
   output logic                 mem_wdata_valid,
   input  logic                 mem_wdata_ready,
   input  logic [word_bits-1:0] mem_rdata,
   input  logic                 mem_rdata_valid
);
   localparam int unsigned beats     = line_bits / word_bits;
   localparam int unsigned cnt_bits  = $clog2(beats);
   localparam logic [31:0] addr_mask = ~(32'(line_bits / 8) - 32'd1);
   rvga_bridge_state_e   state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic                 skip_q, skip_d;
   logic                 clr, adv, load, last;
   logic [cnt_bits-1:0]  cnt;
   logic [word_bits-1:0] word;
   assign last = cnt == cnt_bits'(beats - 1);
   l1cache_mem_beat_buffer #(.line_bits(line_bits), .word_bits(word_bits)) u_buf (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr),
      .adv_i  (adv),
      .load_i (load),
      .word_i (mem_rdata),
      .wline_i(l1cache_ddr_wdata),
      .cnt_o  (cnt),
      .word_o (word),
      .line_o (ddr_l1cache_rdata)
   );
   // next state, buffer controls and bus outputs; skip blocks resampling the request right after resp
   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      skip_d           = 1'b0;
      clr              = 1'b0;
      adv              = 1'b0;
      load             = 1'b0;
      ddr_l1cache_resp = 1'b0;
      mem_cmd_valid    = 1'b0;
      mem_cmd_write    = 1'b0;
      mem_cmd_addr     = '0;
      mem_wdata        = '0;
      mem_wdata_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!skip_q && (l1cache_ddr_write || l1cache_ddr_read)) begin
               addr_d  = l1cache_ddr_addr & addr_mask;
               state_d = l1cache_ddr_write ? CMD_W : CMD_R;
            end
         end
         CMD_R, CMD_W: begin
            mem_cmd_valid = 1'b1;
            mem_cmd_write = state_q == CMD_W;
            mem_cmd_addr  = addr_q;
            clr           = mem_cmd_ready;
            if (mem_cmd_ready) state_d = state_q == CMD_W ? WDATA : RDATA;
         end
         RDATA: begin
            load = mem_rdata_valid;
            adv  = mem_rdata_valid;
            if (mem_rdata_valid && last) state_d = RESP;
         end
         WDATA: begin
            mem_wdata_valid = 1'b1;
            mem_wdata       = word;
            adv             = mem_wdata_ready;
            if (mem_wdata_ready && last) state_d = RESP;
         end
         RESP: begin
            ddr_l1cache_resp = 1'b1;
            skip_d           = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state, latched line address and post-resp skip flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         skip_q  <= skip_d;
      end
   end
endmodule

// File: tb/tb_l1cache_mem_bridge.sv
// tb_l1cache_mem_bridge: randomized bursts checked each cycle against a transaction-level model
module tb_l1cache_mem_bridge;
   typedef logic [255:0] line_t;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] l1cache_ddr_addr;
   logic        l1cache_ddr_read, l1cache_ddr_write;
   line_t       l1cache_ddr_wdata, ddr_l1cache_rdata;
   logic        ddr_l1cache_resp, mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
   logic [31:0] mem_cmd_addr, mem_wdata, mem_rdata;
   logic        mem_wdata_valid, mem_wdata_ready, mem_rdata_valid;
   logic [31:0] mbuf [8];
   int          errs = 0;
   int          checks = 0;
   always #5 clk = ~clk;
   l1cache_mem_bridge dut (
      .clk              (clk),
      .rst              (rst),
      .l1cache_ddr_addr (l1cache_ddr_addr),
      .l1cache_ddr_read (l1cache_ddr_read),
      .l1cache_ddr_write(l1cache_ddr_write),
      .l1cache_ddr_wdata(l1cache_ddr_wdata),
      .ddr_l1cache_rdata(ddr_l1cache_rdata),
      .ddr_l1cache_resp (ddr_l1cache_resp),
      .mem_cmd_valid    (mem_cmd_valid),
      .mem_cmd_ready    (mem_cmd_ready),
      .mem_cmd_write    (mem_cmd_write),
      .mem_cmd_addr     (mem_cmd_addr),
      .mem_wdata        (mem_wdata),
      .mem_wdata_valid  (mem_wdata_valid),
      .mem_wdata_ready  (mem_wdata_ready),
      .mem_rdata        (mem_rdata),
      .mem_rdata_valid  (mem_rdata_valid)
   );
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic line_t mline();
      line_t l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = mbuf[i];
      return l;
   endfunction
   task automatic chk_zero(input string tag);
      chk({tag, ".resp"}, 256'(ddr_l1cache_resp), 0);
      chk({tag, ".cmd_valid"}, 256'(mem_cmd_valid), 0);
      chk({tag, ".cmd_write"}, 256'(mem_cmd_write), 0);
      chk({tag, ".cmd_addr"}, 256'(mem_cmd_addr), 0);
      chk({tag, ".wdata"}, 256'(mem_wdata), 0);
      chk({tag, ".wdata_valid"}, 256'(mem_wdata_valid), 0);
      chk({tag, ".rdata"}, ddr_l1cache_rdata, 0);
   endtask
   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         l1cache_ddr_read  = 1'b0;
         l1cache_ddr_write = 1'b0;
         mem_cmd_ready     = 1'($urandom);
         mem_wdata_ready   = 1'($urandom);
         mem_rdata_valid   = 1'($urandom);
         mem_rdata         = $urandom();
         @(negedge clk);
         chk("idle.resp", 256'(ddr_l1cache_resp), 0);
         chk("idle.cmd_valid", 256'(mem_cmd_valid), 0);
         chk("idle.wdata_valid", 256'(mem_wdata_valid), 0);
         chk("idle.rdata", ddr_l1cache_rdata, mline());
      end
   endtask
   // mode: 0 always ready, 1 toggling ready, 2 random, 3 cmd_ready low 5 cycles then always ready
   task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr, input line_t line,
                       input int mode, input int abort_beat, output logic [31:0] first_addr, output int resp_cyc);
      int  phase, beat, cmd_cyc;
      bit  is_w, got_addr, aborted;
      logic [31:0] ea;
      phase = 0; beat = 0; cmd_cyc = 0; is_w = wr; got_addr = 0; aborted = 0;
      ea = addr & ~32'd31;
      first_addr = '0;
      resp_cyc = -1;
      for (int cyc = 0; cyc < 300 && phase != 4; cyc++) begin
         @(posedge clk); #1;
         if (abort_beat >= 0 && phase == 2 && beat == abort_beat) begin
            rst = 1'b0;
            l1cache_ddr_read  = 1'b0;
            l1cache_ddr_write = 1'b0;
            #1;
            for (int i = 0; i < 8; i++) mbuf[i] = '0;
            chk_zero("abort");
            aborted = 1;
            break;
         end
         l1cache_ddr_read  = rd;
         l1cache_ddr_write = wr;
         l1cache_ddr_addr  = addr;
         l1cache_ddr_wdata = line;
         mem_cmd_ready     = mode == 0 ? 1'b1 : mode == 1 ? (cyc & 1) != 0 : mode == 3 ? cmd_cyc >= 5 : 1'($urandom);
         mem_wdata_ready   = mode == 0 || mode == 3 ? 1'b1 : mode == 1 ? (cyc & 1) != 0 : 1'($urandom);
         mem_rdata_valid   = (!is_w && phase == 2) ? (mode == 0 || mode == 3 ? 1'b1 : 1'($urandom)) : 1'($urandom);
         mem_rdata         = (!is_w && phase == 2) ? line[beat*32 +: 32] : $urandom();
         @(negedge clk);
         chk("resp", 256'(ddr_l1cache_resp), 256'(phase == 3));
         chk("cmd_valid", 256'(mem_cmd_valid), 256'(phase == 1));
         chk("wdata_valid", 256'(mem_wdata_valid), 256'(phase == 2 && is_w));
         chk("rdata", ddr_l1cache_rdata, mline());
         if (phase == 1) begin
            chk("cmd_addr", 256'(mem_cmd_addr), 256'(ea));
            chk("cmd_write", 256'(mem_cmd_write), 256'(is_w));
            if (!got_addr) first_addr = mem_cmd_addr;
            got_addr = 1;
         end
         if (phase == 2 && is_w) chk("wdata", 256'(mem_wdata), 256'(line[beat*32 +: 32]));
         case (phase)
            0: phase = 1;
            1: begin
               cmd_cyc++;
               if (mem_cmd_ready) phase = 2;
            end
            2: if (is_w ? mem_wdata_ready : mem_rdata_valid) begin
               if (!is_w) mbuf[beat] = mem_rdata;
               beat++;
               if (beat == 8) phase = 3;
            end
            3: begin
               resp_cyc = cyc;
               phase = 4;
            end
            default: phase = 4;
         endcase
      end
      if (aborted) begin
         repeat (2) begin
            @(negedge clk);
            chk_zero("in_reset");
         end
         rst = 1'b1;
      end else if (phase != 4) begin
         checks++;
         errs++;
         $display("FAIL timeout: phase %0d beat %0d, required completion", phase, beat);
      end
      idle_cycles(1);
   endtask
   initial begin
      logic [31:0] fa;
      int          rc;
      line_t       rd_line, wr_line;
      rd_line = 256'h00001007_00001006_00001005_00001004_00001003_00001002_00001001_00001000;
      wr_line = 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
      rst = 1'b0;
      l1cache_ddr_addr = '0; l1cache_ddr_read = 0; l1cache_ddr_write = 0; l1cache_ddr_wdata = '0;
      mem_cmd_ready = 0; mem_wdata_ready = 0; mem_rdata = '0; mem_rdata_valid = 0;
      for (int i = 0; i < 8; i++) mbuf[i] = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      idle_cycles(4);
      xfer(1, 0, 32'h0000_1234, rd_line, 0, -1, fa, rc);
      chk("rd.addr_lit", 256'(fa), 256'(32'h0000_1220));
      chk("rd.latency", 256'(rc), 256'(10));
      chk("rd.line_lit", ddr_l1cache_rdata, rd_line);
      xfer(0, 1, 32'h0000_2000, wr_line, 1, -1, fa, rc);
      chk("wr.addr_lit", 256'(fa), 256'(32'h0000_2000));
      chk("wr.rdata_held", ddr_l1cache_rdata, rd_line);
      xfer(1, 1, 32'h0000_0040, {8{32'h5A5A_0001}}, 2, -1, fa, rc);
      chk("both.addr_lit", 256'(fa), 256'(32'h0000_0040));
      xfer(1, 0, 32'h0000_3000, {8{32'hC0DE_0000}} ^ line_t'($urandom()), 3, -1, fa, rc);
      xfer(0, 1, 32'h0000_3100, {8{32'h1357_9BDF}}, 3, -1, fa, rc);
      xfer(1, 0, 32'h0000_4000, {8{$urandom()}}, 0, 4, fa, rc);
      idle_cycles(2);
      xfer(1, 0, 32'h0000_0080, rd_line ^ {8{32'hFFFF_0000}}, 0, -1, fa, rc);
      chk("post_rst.addr_lit", 256'(fa), 256'(32'h0000_0080));
      chk("post_rst.latency", 256'(rc), 256'(10));
      for (int t = 0; t < 24; t++) begin
         int    k;
         line_t l;
         k = $urandom_range(0, 2);
         for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
         xfer(k != 1, k != 0, $urandom(), l, $urandom_range(0, 3), -1, fa, rc);
         idle_cycles($urandom_range(0, 3));
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end
endmodule
